// File: rtl/ro_scan_sequencer.sv
// Ring-oscillator scan sequencer: steps the 16:1 mux, sequences enable/warm-up, and counts edges per ring.
// Optional RO_SCAN_CONTINUOUS_EN: wrap back to oscillator 0 after the last result instead of stopping.
module ro_scan_sequencer #(
    parameter int NUM_RO     = 16,
    parameter int GATE_CYC   = 1024,
    parameter int SETTLE_CYC = 16,
    parameter int CNT_W      = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic             scan_start_i,
    input  logic             abort_i,
    input  logic [4:0]       variant_i,
    input  logic             ro_in_i,
    output logic [3:0]       ro_sel_o,
    output logic [4:0]       ro_variant_o,
    output logic             ro_start_o,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [CNT_W-1:0] res_data_o,
    output logic [3:0]       res_idx_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETUP   = 3'd1;
    localparam logic [2:0] ST_ENABLE  = 3'd2;
    localparam logic [2:0] ST_MEASURE = 3'd3;
    localparam logic [2:0] ST_STORE   = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    localparam int MAX_CYC = (GATE_CYC > SETTLE_CYC) ? GATE_CYC : SETTLE_CYC;
    localparam int TW      = $clog2(MAX_CYC);

    localparam logic [TW-1:0]    SETTLE_LAST = TW'(SETTLE_CYC - 1);
    localparam logic [TW-1:0]    GATE_LAST   = TW'(GATE_CYC - 1);
    localparam logic [3:0]       LAST_IDX    = 4'(NUM_RO - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    logic [2:0]       state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [3:0]       idx_q, idx_d;
    logic [4:0]       variant_q, variant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [CNT_W-1:0] res_data_q, res_data_d;
    logic [3:0]       res_idx_q, res_idx_d;
    logic             valid_q, valid_d;
    logic             start_q, start_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [2:0]       sync_q;
    logic             ro_rise;

    // sync_q[1:0] is the metastability synchroniser, sync_q[2] the edge-detect history flop
    assign ro_rise = sync_q[1] & ~sync_q[2];
    assign cnt_inc = (ro_rise && (cnt_q != CNT_MAX)) ? cnt_q + 1'b1 : cnt_q;

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q + 1'b1;
        idx_d      = idx_q;
        variant_d  = variant_q;
        cnt_d      = cnt_q;
        res_data_d = res_data_q;
        res_idx_d  = res_idx_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (scan_start_i) begin
                    variant_d = variant_i;
                    idx_d     = 4'd0;
                    state_d   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (timer_q == SETTLE_LAST) begin
                    timer_d = '0;
                    state_d = ST_ENABLE;
                end
            end
            ST_ENABLE: begin
                if (timer_q == SETTLE_LAST) begin
                    timer_d = '0;
                    cnt_d   = '0;
                    state_d = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                cnt_d = cnt_inc;
                if (timer_q == GATE_LAST) begin
                    timer_d    = '0;
                    res_data_d = cnt_inc;
                    res_idx_d  = idx_q;
                    state_d    = ST_STORE;
                end
            end
            ST_STORE: begin
                timer_d = '0;
                if (valid_q && res_ready_i) begin
                    if (idx_q == LAST_IDX) begin
                        done_d = 1'b1;
`ifdef RO_SCAN_CONTINUOUS_EN
                        idx_d   = 4'd0;
                        state_d = ST_SETUP;
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = ST_SETUP;
                    end
                end
            end
            ST_DONE: begin
                timer_d = '0;
                idx_d   = 4'd0;
                state_d = ST_IDLE;
            end
            default: begin
                timer_d = '0;
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides everything decided above, including a completing handshake
        if (abort_i) begin
            state_d = ST_IDLE;
            timer_d = '0;
            idx_d   = 4'd0;
            done_d  = 1'b0;
        end

        start_d = (state_d == ST_ENABLE) || (state_d == ST_MEASURE) || (state_d == ST_STORE);
        valid_d = (state_d == ST_STORE);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            idx_q      <= '0;
            variant_q  <= '0;
            cnt_q      <= '0;
            res_data_q <= '0;
            res_idx_q  <= '0;
            valid_q    <= 1'b0;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sync_q     <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            idx_q      <= idx_d;
            variant_q  <= variant_d;
            cnt_q      <= cnt_d;
            res_data_q <= res_data_d;
            res_idx_q  <= res_idx_d;
            valid_q    <= valid_d;
            start_q    <= start_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sync_q     <= {sync_q[1:0], ro_in_i};
        end
    end

    assign ro_sel_o     = idx_q;
    assign ro_variant_o = variant_q;
    assign ro_start_o   = start_q;
    assign res_valid_o  = valid_q;
    assign res_data_o   = res_data_q;
    assign res_idx_o    = res_idx_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_ro_scan_sequencer.sv
// Bench for ro_scan_sequencer: a 16-bit instance for counts and timing, a 4-bit instance in lockstep for saturation.
// Expected counts come from frequency times gate window; RO_SCAN_CONTINUOUS_EN switches to three-pass expectations.
module tb_ro_scan_sequencer;

    localparam int NUM_RO     = 4;
    localparam int GATE_CYC   = 64;
    localparam int SETTLE_CYC = 4;
    localparam int CNT_W      = 16;
    localparam int SAT_W      = 4;
    localparam int SLOT       = 2 * SETTLE_CYC + GATE_CYC + 1;
`ifdef RO_SCAN_CONTINUOUS_EN
    localparam int PASSES = 3;
`else
    localparam int PASSES = 1;
`endif

    typedef struct {
        logic [4:0] variant;
        int         half;
        int         expData;
        bit         randStall;
        bit         checkTiming;
    } scanVec_t;

    logic             wbClk = 1'b0;
    logic             rstN = 1'b0;
    logic             scanStart = 1'b0;
    logic             abortIn = 1'b0;
    logic             readyIn = 1'b0;
    logic [4:0]       variantIn = 5'd0;
    logic             roIn = 1'b0;
    logic             roFast = 1'b0;
    int               roHalf = 0;
    int               halfPrev = 0;
    int               roPhase = 0;
    int               cyc = 0;
    int               checks = 0;
    int               errors = 0;

    logic [3:0]       roSel, satSel;
    logic [4:0]       roVariant, satVariant;
    logic             roStartO, satStart;
    logic             resValid, satValid;
    logic [CNT_W-1:0] resData;
    logic [SAT_W-1:0] satData;
    logic [3:0]       resIdx, satIdx;
    logic             busyO, satBusy;
    logic             doneO, satDone;

    ro_scan_sequencer #(
        .NUM_RO(NUM_RO), .GATE_CYC(GATE_CYC), .SETTLE_CYC(SETTLE_CYC), .CNT_W(CNT_W)
    ) dut (
        .wb_clk_i(wbClk), .wb_rst_ni(rstN), .scan_start_i(scanStart), .abort_i(abortIn),
        .variant_i(variantIn), .ro_in_i(roIn), .ro_sel_o(roSel), .ro_variant_o(roVariant),
        .ro_start_o(roStartO), .res_valid_o(resValid), .res_ready_i(readyIn),
        .res_data_o(resData), .res_idx_o(resIdx), .busy_o(busyO), .done_o(doneO)
    );

    ro_scan_sequencer #(
        .NUM_RO(NUM_RO), .GATE_CYC(GATE_CYC), .SETTLE_CYC(SETTLE_CYC), .CNT_W(SAT_W)
    ) dutSat (
        .wb_clk_i(wbClk), .wb_rst_ni(rstN), .scan_start_i(scanStart), .abort_i(abortIn),
        .variant_i(variantIn), .ro_in_i(roFast), .ro_sel_o(satSel), .ro_variant_o(satVariant),
        .ro_start_o(satStart), .res_valid_o(satValid), .res_ready_i(readyIn),
        .res_data_o(satData), .res_idx_o(satIdx), .busy_o(satBusy), .done_o(satDone)
    );

    always #5 wbClk = ~wbClk;

    always @(posedge wbClk) cyc <= cyc + 1;

    // Oscillator stand-ins: roFast toggles every cycle, roIn toggles every roHalf cycles (0 holds it)
    always @(posedge wbClk) begin
        #2;
        roFast = ~roFast;
        if (roHalf != halfPrev) begin
            roPhase  = 0;
            halfPrev = roHalf;
        end else if (roHalf > 0) begin
            if (roPhase + 1 >= roHalf) begin
                roPhase = 0;
                roIn    = ~roIn;
            end else begin
                roPhase++;
            end
        end
    end

    task automatic step();
        @(posedge wbClk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "Sel"},     int'(roSel),     0);
        checkOutput({tag, "Variant"}, int'(roVariant), 0);
        checkOutput({tag, "Start"},   int'(roStartO),  0);
        checkOutput({tag, "Valid"},   int'(resValid),  0);
        checkOutput({tag, "Data"},    int'(resData),   0);
        checkOutput({tag, "Idx"},     int'(resIdx),    0);
        checkOutput({tag, "Busy"},    int'(busyO),     0);
        checkOutput({tag, "Done"},    int'(doneO),     0);
        checkOutput({tag, "SatData"}, int'(satData),   0);
    endtask

    task automatic waitValid(input int budget);
        int w;
        w = 0;
        while (!resValid && w < budget) begin
            step();
            w++;
        end
        checkOutput("validSeen", int'(resValid), 1);
    endtask

    // One full scan (PASSES passes), checking every result against the vector's expected count
    task automatic applyStimulus(input scanVec_t sv);
        int got, c0, total, w;
        bit expDone;
        total   = NUM_RO * PASSES;
        got     = 0;
        expDone = 1'b0;
        roHalf    = sv.half;
        variantIn = sv.variant;
        readyIn   = 1'b1;
        scanStart = 1'b1;
        step();
        scanStart = 1'b0;
        variantIn = ~sv.variant;
        c0 = cyc;
        checkOutput("busyRise", int'(busyO), 1);
        checkOutput("setupStartLow", int'(roStartO), 0);
        checkOutput("setupSel", int'(roSel), 0);
        w = 0;
        while (got < total && w < 20000) begin
            readyIn = sv.randStall ? ($urandom_range(0, 2) != 0) : 1'b1;
            checkOutput("donePulse", int'(doneO), int'(expDone));
            expDone = 1'b0;
            if (resValid) begin
                if (sv.checkTiming) checkOutput("validCycle", cyc - c0, got * SLOT + SLOT - 1);
                checkOutput("resIdx", int'(resIdx), got % NUM_RO);
                checkOutput("resData", int'(resData), sv.expData);
                checkOutput("selMatch", int'(roSel), got % NUM_RO);
                checkOutput("variantLatched", int'(roVariant), int'(sv.variant));
                checkOutput("startHeld", int'(roStartO), 1);
                checkOutput("satValid", int'(satValid), 1);
                checkOutput("satData", int'(satData), (1 << SAT_W) - 1);
                if (readyIn) begin
                    got++;
                    expDone = ((got % NUM_RO) == 0);
                end
            end
            step();
            w++;
        end
        checkOutput("scanResults", got, total);
        checkOutput("doneFinal", int'(doneO), 1);
        if (sv.checkTiming) checkOutput("doneCycle", cyc - c0, PASSES * NUM_RO * SLOT);
        readyIn = 1'b0;
`ifdef RO_SCAN_CONTINUOUS_EN
        checkOutput("wrapSel", int'(roSel), 0);
        checkOutput("wrapBusy", int'(busyO), 1);
        abortIn = 1'b1;
        step();
        abortIn = 1'b0;
`else
        step();
`endif
        checkOutput("idleBusy", int'(busyO), 0);
        checkOutput("idleDone", int'(doneO), 0);
    endtask

    task automatic backpressureAbort();
        bit bad;
        roHalf    = 4;
        variantIn = 5'h0C;
        readyIn   = 1'b1;
        scanStart = 1'b1;
        step();
        scanStart = 1'b0;
        waitValid(200);
        step();
        readyIn = 1'b0;
        waitValid(200);
        for (int i = 0; i < 10; i++) begin
            checkOutput("bpValid", int'(resValid), 1);
            checkOutput("bpIdx", int'(resIdx), 1);
            checkOutput("bpData", int'(resData), 8);
            checkOutput("bpStart", int'(roStartO), 1);
            step();
        end
        readyIn = 1'b1;
        checkOutput("bpStillValid", int'(resValid), 1);
        step();
        checkOutput("bpAdvanceSel", int'(roSel), 2);
        checkOutput("bpValidDrop", int'(resValid), 0);
        repeat (2 * SETTLE_CYC + GATE_CYC / 2) step();
        checkOutput("preAbortStart", int'(roStartO), 1);
        abortIn   = 1'b1;
        scanStart = 1'b1;
        step();
        abortIn   = 1'b0;
        scanStart = 1'b0;
        checkOutput("abortBusy", int'(busyO), 0);
        checkOutput("abortStart", int'(roStartO), 0);
        checkOutput("abortValid", int'(resValid), 0);
        checkOutput("abortDone", int'(doneO), 0);
        bad = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (resValid || doneO || busyO || roStartO) bad = 1'b1;
            step();
        end
        checkOutput("abortQuiet", int'(bad), 0);
    endtask

    task automatic resetMidScan();
        scanVec_t sv;
        roHalf    = 2;
        variantIn = 5'h13;
        readyIn   = 1'b0;
        scanStart = 1'b1;
        step();
        scanStart = 1'b0;
        waitValid(200);
        rstN = 1'b0;
        step();
        rstN = 1'b1;
        checkResetOutputs("rstMid");
        sv = '{5'h06, 2, 16, 1'b0, 1'b0};
        applyStimulus(sv);
    endtask

    initial begin
        scanVec_t vecs[4];
        scanVec_t rv;
        int halves[6];
        vecs[0] = '{5'h15, 4,  8,  1'b0, 1'b1};
        vecs[1] = '{5'h0A, 2,  16, 1'b1, 1'b0};
        vecs[2] = '{5'h1F, 8,  4,  1'b0, 1'b1};
        vecs[3] = '{5'h01, 32, 1,  1'b1, 1'b0};
        halves  = '{1, 2, 4, 8, 16, 32};

        rstN = 1'b0;
        repeat (3) step();
        checkResetOutputs("reset");
        rstN = 1'b1;
        step();

        for (int i = 0; i < 4; i++) applyStimulus(vecs[i]);

        backpressureAbort();
        resetMidScan();

        for (int i = 0; i < 4; i++) begin
            rv.variant     = 5'($urandom);
            rv.half        = halves[$urandom_range(0, 5)];
            rv.expData     = GATE_CYC / (2 * rv.half);
            rv.randStall   = 1'b1;
            rv.checkTiming = 1'b0;
            applyStimulus(rv);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
